// File: rtl/soft_trig_scheduler.sv
// rtl/soft_trig_scheduler.sv - round-robin soft-event scheduler gated by the EVG machine trigger
// Optional ARMED timeout and sticky tmo_flag built when SOFT_TRIG_TIMEOUT_EN is defined.
module soft_trig_scheduler #(
    parameter int N_REQ   = 4,
    parameter int ID_W    = 2,
    parameter int DLY_W   = 16,
    parameter int TMO_CYC = 250000000
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             clk_enable,
    input  logic             evg_trig,
    input  logic [N_REQ-1:0] soft_event,
    input  logic [N_REQ-1:0] req_mask,
    input  logic [DLY_W-1:0] delay_cfg,
    input  logic [7:0]       pulse_len,
    input  logic             tmo_clr,
    output logic [N_REQ-1:0] trig_out,
    output logic [N_REQ-1:0] pending,
    output logic [ID_W-1:0]  grant_id,
    output logic             busy,
    output logic [N_REQ-1:0] tmo_flag
);

    typedef enum logic [1:0] {IDLE, ARMED, DELAY, PULSE} state_t;

    state_t           state;
    logic [N_REQ-1:0] sync1, sync2, sync3;
    logic             evg_trig_d;
    logic [N_REQ-1:0] ev_edge;
    logic             trig_edge;
    logic [ID_W-1:0]  rr_ptr;
    logic [ID_W-1:0]  next_ptr;
    logic [ID_W:0]    pick_sum;
    logic [ID_W-1:0]  pick_idx;
    logic [ID_W-1:0]  pick_id;
    logic             pick_found;
    logic [DLY_W-1:0] cnt;
    logic [7:0]       pcnt;
    logic [7:0]       plen_eff;
    logic [N_REQ-1:0] grant_onehot;
    logic             armed_live;
    logic [N_REQ-1:0] grant_clr;
    logic             tmo_hit;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            sync1      <= '0;
            sync2      <= '0;
            sync3      <= '0;
            evg_trig_d <= 1'b0;
        end else begin
            sync1      <= soft_event;
            sync2      <= sync1;
            sync3      <= sync2;
            evg_trig_d <= evg_trig;
        end
    end

    assign ev_edge      = sync2 & ~sync3;
    assign trig_edge    = evg_trig & ~evg_trig_d;
    assign grant_onehot = N_REQ'(1) << grant_id;
    assign plen_eff     = (pulse_len == 8'd0) ? 8'd1 : pulse_len;
    assign next_ptr     = (grant_id == ID_W'(N_REQ - 1)) ? '0 : grant_id + ID_W'(1);
    assign armed_live   = clk_enable && (state == ARMED) && pending[grant_id];
    assign grant_clr    = (armed_live && (trig_edge || tmo_hit)) ? grant_onehot : '0;

    // Scan downwards so the lowest offset from rr_ptr is the final winner.
    always_comb begin
        pick_found = 1'b0;
        pick_id    = '0;
        pick_sum   = '0;
        pick_idx   = '0;
        for (int j = N_REQ - 1; j >= 0; j--) begin
            pick_sum = {1'b0, rr_ptr} + (ID_W + 1)'(j);
            if (pick_sum >= (ID_W + 1)'(N_REQ))
                pick_sum = pick_sum - (ID_W + 1)'(N_REQ);
            pick_idx = pick_sum[ID_W-1:0];
            if (pending[pick_idx]) begin
                pick_found = 1'b1;
                pick_id    = pick_idx;
            end
        end
    end

    // A fresh edge is OR-ed in after the grant clear, so a colliding request stays queued.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset)
            pending <= '0;
        else if (clk_enable)
            pending <= ((pending & ~grant_clr) | ev_edge) & req_mask;
    end

`ifdef SOFT_TRIG_TIMEOUT_EN
    localparam int TMO_W = $clog2(TMO_CYC + 1);

    logic [TMO_W-1:0] tmo_cnt;
    logic [N_REQ-1:0] tmo_set;

    assign tmo_hit = (state == ARMED) && !trig_edge && (tmo_cnt == TMO_W'(TMO_CYC - 1));
    assign tmo_set = (armed_live && tmo_hit) ? grant_onehot : '0;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset)
            tmo_cnt <= '0;
        else if (clk_enable)
            tmo_cnt <= (state == ARMED) ? tmo_cnt + TMO_W'(1) : '0;
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset)
            tmo_flag <= '0;
        else
            tmo_flag <= (tmo_clr ? '0 : tmo_flag) | tmo_set;
    end
`else
    logic unused_tmo;

    assign tmo_hit    = 1'b0;
    assign tmo_flag   = '0;
    assign unused_tmo = tmo_clr ^ (TMO_CYC == 0);
`endif

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state    <= IDLE;
            rr_ptr   <= '0;
            grant_id <= '0;
            busy     <= 1'b0;
            trig_out <= '0;
            cnt      <= '0;
            pcnt     <= '0;
        end else if (clk_enable) begin
            case (state)
                IDLE: begin
                    if (pick_found) begin
                        grant_id <= pick_id;
                        state    <= ARMED;
                        busy     <= 1'b1;
                    end
                end
                ARMED: begin
                    if (!pending[grant_id]) begin
                        state <= IDLE;
                        busy  <= 1'b0;
                    end else if (trig_edge) begin
                        cnt <= delay_cfg;
                        if (delay_cfg == '0) begin
                            state    <= PULSE;
                            trig_out <= grant_onehot;
                            pcnt     <= plen_eff;
                        end else begin
                            state <= DELAY;
                        end
                    end else if (tmo_hit) begin
                        state  <= IDLE;
                        busy   <= 1'b0;
                        rr_ptr <= next_ptr;
                    end
                end
                DELAY: begin
                    if (cnt == DLY_W'(1)) begin
                        state    <= PULSE;
                        trig_out <= grant_onehot;
                        pcnt     <= plen_eff;
                    end else begin
                        cnt <= cnt - DLY_W'(1);
                    end
                end
                PULSE: begin
                    if (pcnt <= 8'd1) begin
                        trig_out <= '0;
                        state    <= IDLE;
                        busy     <= 1'b0;
                        rr_ptr   <= next_ptr;
                    end else begin
                        pcnt <= pcnt - 8'd1;
                    end
                end
                default: begin
                    state <= IDLE;
                    busy  <= 1'b0;
                end
            endcase
        end
    end

endmodule
